// File: rtl/fifo_pkg.sv
// Shared sizing defaults and pointer/count width helpers for fifo_cond.
package fifo_pkg;

    localparam int DATA_W_DEF = 10;
    localparam int DEPTH_DEF  = 8;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    // One extra bit so the count can represent a completely full FIFO.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/memoria_dp.sv
// DEPTH x DATA_W register array: synchronous write port, registered read port.
// Read data appears one cycle after rd_en and holds until the next read.
// No flow control here; the owner guarantees valid enables and addresses.
module memoria_dp
    import fifo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [ptr_w(DEPTH)-1:0]  wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    input  logic [ptr_w(DEPTH)-1:0]  rd_addr,
    output logic [DATA_W-1:0]        rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_cond.sv
// Single-clock FIFO with count/threshold flags; FIFO_ERR_EN enables sticky error.
// Push-to-pop latency one cycle; data_out registered, valid the cycle after a pop.
// Push while full and pop while empty are dropped with no state change.
module fifo_cond
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int DEPTH     = DEPTH_DEF,
    parameter int ALM_FULL  = 6,
    parameter int ALM_EMPTY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        data_in,
    input  logic                     pop,
    output logic [DATA_W-1:0]        data_out,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     empty,
    output logic                     full,
    output logic                     alm_full,
    output logic                     alm_empty,
    output logic                     error
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign push_ok = push && (count_q < CNT_W'(DEPTH));
    assign pop_ok  = pop  && (count_q != '0);

    // DEPTH is a power of two, so pointer wrap is the natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    memoria_dp #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_ok),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (pop_ok),
        .rd_addr (rd_ptr_q),
        .rd_data (data_out)
    );

    assign count     = count_q;
    assign empty     = (count_q == '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign alm_full  = (count_q >= CNT_W'(ALM_FULL));
    assign alm_empty = (count_q <= CNT_W'(ALM_EMPTY));

`ifdef FIFO_ERR_EN
    logic error_q, error_d;

    // Judged on the pre-edge state: push into full or pop from empty.
    always_comb begin
        error_d = error_q | (push && full) | (pop && empty);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_cond.sv
// Directed bench for fifo_cond: queue-based reference model checked every cycle.
module tb_fifo_cond;

    localparam int DW    = 10;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          pop = 1'b0;
    logic [DW-1:0] data_out;
    logic [3:0]    count;
    logic          empty, full, alm_full, alm_empty, error;

    fifo_cond dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .data_in   (data_in),
        .pop       (pop),
        .data_out  (data_out),
        .count     (count),
        .empty     (empty),
        .full      (full),
        .alm_full  (alm_full),
        .alm_empty (alm_empty),
        .error     (error)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    // Reference model: contents as a queue, plus the last word read out.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_dout = '0;
    bit            m_err  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_dout = '0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge(input bit p, input logic [DW-1:0] d, input bit q);
        int  n;
        bit  p_ok, q_ok;
        n    = m_q.size();
        p_ok = p && (n < DEPTH);
        q_ok = q && (n > 0);
        if ((p && n == DEPTH) || (q && n == 0)) m_err = 1'b1;
        if (q_ok) m_dout = m_q.pop_front();
        if (p_ok) m_q.push_back(d);
    endtask

    task automatic step(input bit p, input logic [DW-1:0] d, input bit q);
        push    = p;
        data_in = d;
        pop     = q;
        @(posedge clk);
        model_edge(p, d, q);
        @(negedge clk);
        push = 1'b0;
        pop  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            int  n;
            bit  exp_err;
            n = m_q.size();
`ifdef FIFO_ERR_EN
            exp_err = m_err;
`else
            exp_err = 1'b0;
`endif
            chk("count",     32'(count),     32'(n));
            chk("empty",     32'(empty),     32'(n == 0));
            chk("full",      32'(full),      32'(n == DEPTH));
            chk("alm_full",  32'(alm_full),  32'(n >= 6));
            chk("alm_empty", 32'(alm_empty), 32'(n <= 2));
            chk("data_out",  32'(data_out),  32'(m_dout));
            chk("error",     32'(error),     32'(exp_err));
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst    = 1'b0;
        chk_en = 1'b1;

        // Idle after reset.
        step(0, '0, 0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_dout",  32'(data_out), 32'd0);

        // Fill 1..8 and pin threshold edges.
        for (int i = 1; i <= 8; i++) begin
            step(1, DW'(i), 0);
            chk("fill_count", 32'(count), 32'(i));
            if (i == 2) chk("alm_empty_at2", 32'(alm_empty), 32'd1);
            if (i == 3) chk("alm_empty_at3", 32'(alm_empty), 32'd0);
            if (i == 5) chk("alm_full_at5",  32'(alm_full),  32'd0);
            if (i == 6) chk("alm_full_at6",  32'(alm_full),  32'd1);
            if (i == 7) chk("full_at7",      32'(full),      32'd0);
            if (i == 8) chk("full_at8",      32'(full),      32'd1);
        end
        for (int i = 1; i <= 8; i++) begin
            step(0, '0, 1);
            chk("drain_dout", 32'(data_out), 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);

        // Push and pop together while empty: only the push lands.
        step(1, 10'h155, 1);
        chk("both_empty_count", 32'(count), 32'd1);
        chk("both_empty_dout",  32'(data_out), 32'h008);
        step(0, '0, 1);
        chk("pop_155", 32'(data_out), 32'h155);
        // Pop while empty is dropped.
        step(0, '0, 1);
        chk("underflow_dout", 32'(data_out), 32'h155);

        // Overflow: fill, push 0x3FF, then confirm contents unchanged.
        for (int i = 0; i < 8; i++) step(1, DW'(16 + i), 0);
        step(1, 10'h3FF, 0);
        chk("ovf_count", 32'(count), 32'd8);
        step(1, 10'h3FE, 1);
        chk("full_both_count", 32'(count), 32'd7);
        chk("full_both_dout",  32'(data_out), 32'h010);
        for (int i = 1; i < 8; i++) begin
            step(0, '0, 1);
            chk("ovf_drain", 32'(data_out), 32'(16 + i));
        end

        // Steady state at 4 with concurrent push/pop; pointers wrap.
        for (int i = 0; i < 4; i++) step(1, DW'(10'h100 + i), 0);
        for (int i = 0; i < 10; i++) begin
            step(1, DW'(10'h200 + i), 1);
            chk("steady_count", 32'(count), 32'd4);
        end
        chk("steady_last", 32'(data_out), 32'h205);

        // Asynchronous reset between edges at count 5.
        step(1, 10'h0AA, 0);
        chk("pre_rst_count", 32'(count), 32'd5);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("arst_count", 32'(count), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        chk("arst_dout",  32'(data_out), 32'd0);
        chk("arst_error", 32'(error), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        step(0, '0, 0);
        step(1, 10'h077, 0);
        step(0, '0, 1);
        chk("post_rst_dout", 32'(data_out), 32'h077);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_cond.md
Name: fifo_cond

Overview:
Synchronous single-clock FIFO that buffers 10-bit words between a producer and one arbiter input or output lane. Four instances sit upstream of arbitro_cond and feed it: empty/data_poped/pop. Four more sit downstream and accept its traffic: push/data_pushed/alm_full. Threshold flags let the arbiter apply back-pressure before overflow.

Parameters:
DATA_W, 10, word width (matches arbiter data_poped/data_pushed)
DEPTH, 8, number of entries; must be a power of 2, >= 4
ALM_FULL, 6, alm_full asserts when count >= ALM_FULL; range 1..DEPTH-1
ALM_EMPTY, 2, alm_empty asserts when count <= ALM_EMPTY; range 0..DEPTH-2

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  asynchronous, active-high reset
push  input  1  write request
data_in  input  DATA_W  word to write; sampled on an accepted push
pop  input  1  read request
data_out  output  DATA_W  registered read data
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
alm_full  output  1  count >= ALM_FULL
alm_empty  output  1  count <= ALM_EMPTY
error  output  1  sticky overflow/underflow flag; see Optional Feature

Behaviour:
- Reset (async, rst=1): wr_ptr=0, rd_ptr=0, count=0, data_out=0, error=0. Flags then read: empty=1, alm_empty=1, full=0, alm_full=0. Memory contents are not cleared. Reset asserted mid-operation aborts any in-flight push or pop immediately.
- Acceptance uses the pre-edge state:
  - push_ok = push & (count < DEPTH)
  - pop_ok = pop & (count > 0)
- Accepted push: mem[wr_ptr] <= data_in; wr_ptr advances by 1 and wraps DEPTH-1 -> 0.
- Accepted pop: data_out <= mem[rd_ptr]; rd_ptr advances by 1 and wraps DEPTH-1 -> 0. data_out is valid in the cycle after the pop edge and holds its value until the next accepted pop.
- count update:
  - +1 on push_ok & !pop_ok
  - -1 on pop_ok & !push_ok
  - unchanged when both or neither are accepted
- Simultaneous push and pop:
  - 0 < count < DEPTH: both accepted, count unchanged.
  - count == DEPTH: pop accepted, push dropped, count becomes DEPTH-1.
  - count == 0: push accepted, pop ignored, count becomes 1. There is no write-through bypass, so data_out keeps its old value.
- Flags are decoded combinationally from the count register. No extra latency: a flag changes in the same cycle that count changes.
- Dropped push or pop: no pointer, count or data change.
- Latency: a word pushed at edge N can be popped at edge N+1 and appears on data_out after edge N+1.

Optional Feature:
FIFO_ERR_EN defined:
- error is set on a push while full, or a pop while empty (pre-edge state).
- error is sticky and cleared only by rst.
Not defined:
- error is tied to 0 and no detection logic is generated.
- The port is present in both builds so the instantiation is unchanged.

Decomposition:
- Shared package (fifo_pkg) holds DATA_W_DEF=10, DEPTH_DEF=8, and the pointer/count width helpers (PTR_W=$clog2(DEPTH), CNT_W=PTR_W+1).
- One sub-module: memoria_dp. It is a DEPTH x DATA_W register array with a synchronous write port (wr_en, wr_addr, wr_data) and a registered read port (rd_en, rd_addr, rd_data).
- fifo_cond keeps the pointers, count, flags and error logic.

Test Plan:
- Reset, then idle -> empty=1, alm_empty=1, full=0, alm_full=0, count=0, data_out=0.
- Push 0x001..0x008 on 8 consecutive cycles:
  - count steps 1..8
  - alm_empty drops when count reaches 3
  - alm_full rises when count reaches 6
  - full rises when count reaches 8
  - then pop 8 times -> data_out 0x001..0x008 in order, empty=1 at the end.
- Fill to 8, then push 0x3FF -> count stays 8 and the contents are unchanged. With FIFO_ERR_EN, error=1 and stays 1 until rst.
- At count=4, push and pop together for 10 cycles -> count holds 4, pointers wrap past 7->0, output order is preserved.
- At count=0, push 0x155 and pop together -> count=1, data_out unchanged. The next pop gives data_out=0x155.
- With count=5, assert rst asynchronously between edges -> count=0, empty=1 and data_out=0 immediately, before the next clk edge.
